macbl_dac_loader: RTL and testbench

//  Upstream feeder for the bit-line DAC interface. Accepts 8-bit DAC codes over a valid/ready

---
 rtl/macbl_pkg.sv | 29 ++
 rtl/macbl_sync_fifo.sv | 68 ++++++
 rtl/macbl_dac_loader.sv | 111 +++++++++++
 tb/tb_macbl_dac_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/macbl_pkg.sv
// Shared types and default timing for the bit-line DAC loader.
// Default windows give a 5-cycle period per code (setup + lock + hold + one idle cycle).
package macbl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    LOCK  = 2'd2,
    HOLD  = 2'd3
  } dac_ld_state_t;

  localparam int DAC_W          = 8;
  localparam int DAC_FIFO_DEPTH = 4;
  localparam int DAC_SETUP_CYC  = 1;
  localparam int DAC_LOCK_CYC   = 2;
  localparam int DAC_HOLD_CYC   = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The window counter only needs to reach max_val-1; keep at least one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/macbl_sync_fifo.sv
// Small synchronous FIFO with a combinational head, so the consumer can pop
// and use the oldest word on the same clock edge.
module macbl_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int COUNT_W = AW + 1;

  logic [W-1:0]       mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               push_ok;
  logic               pop_ok;

  // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == AW'(gi))) begin
          mem[gi] <= wdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == COUNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/macbl_dac_loader.sv
// Feeds buffered DAC codes to the bit-line DAC latch: presents a code, then
// pulses dac_lock_en after a setup window and holds the code for a hold window.
module macbl_dac_loader
  import macbl_pkg::*;
#(
  parameter int DATA_W     = DAC_W,
  parameter int FIFO_DEPTH = DAC_FIFO_DEPTH,
  parameter int SETUP_CYC  = DAC_SETUP_CYC,
  parameter int LOCK_CYC   = DAC_LOCK_CYC,
  parameter int HOLD_CYC   = DAC_HOLD_CYC
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] digital_data,
  output logic              dac_lock_en,
  output logic              busy,
  output logic [15:0]       lock_count
);

  localparam int CNT_W = cnt_width(max3(SETUP_CYC, LOCK_CYC, HOLD_CYC));
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  dac_ld_state_t                 state_reg;
  logic [CNT_W-1:0]              cnt_reg;
  logic [DATA_W-1:0]             digital_data_reg;
  logic                          dac_lock_en_reg;
  logic [15:0]                   lock_count_reg;

  logic [DATA_W-1:0]             fifo_head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          fifo_pop;

  // Only IDLE consumes codes, so digital_data can never move under a lock pulse.
  assign fifo_pop = (state_reg == IDLE) && !fifo_empty;

  macbl_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      digital_data_reg <= '0;
      dac_lock_en_reg  <= 1'b0;
      lock_count_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            digital_data_reg <= fifo_head;
            cnt_reg          <= SETUP_LOAD;
            state_reg        <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_reg == '0) begin
            dac_lock_en_reg <= 1'b1;
            cnt_reg         <= LOCK_LOAD;
            state_reg       <= LOCK;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        LOCK: begin
          if (cnt_reg == '0) begin
            dac_lock_en_reg <= 1'b0;
            cnt_reg         <= HOLD_LOAD;
            lock_count_reg  <= lock_count_reg + 16'd1;
            state_reg       <= HOLD;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready     = !fifo_full;
  assign busy         = (fifo_count != '0) || (state_reg != IDLE);
  assign digital_data = digital_data_reg;
  assign dac_lock_en  = dac_lock_en_reg;
  assign lock_count   = lock_count_reg;

endmodule

// File: tb/tb_macbl_dac_loader.sv
// Directed bench for macbl_dac_loader: a per-cycle vector table for single and
// back-to-back codes, plus hand sequences for full FIFO, reset, timing and wrap.
module tb_macbl_dac_loader;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [7:0]  digital_data;
  logic        dac_lock_en;
  logic        busy;
  logic [15:0] lock_count;

  logic        b_rst_n;
  logic        b_valid;
  logic        b_ready;
  logic [7:0]  b_data;
  logic [7:0]  b_digital;
  logic        b_lock;
  logic        b_busy;
  logic [15:0] b_lc;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  macbl_dac_loader dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .digital_data (digital_data),
    .dac_lock_en  (dac_lock_en),
    .busy         (busy),
    .lock_count   (lock_count)
  );

  macbl_dac_loader #(
    .SETUP_CYC (3),
    .LOCK_CYC  (1),
    .HOLD_CYC  (2)
  ) dut_b (
    .sys_clk      (sys_clk),
    .sys_rst_n    (b_rst_n),
    .in_valid     (b_valid),
    .in_ready     (b_ready),
    .in_data      (b_data),
    .digital_data (b_digital),
    .dac_lock_en  (b_lock),
    .busy         (b_busy),
    .lock_count   (b_lc)
  );

  typedef struct {
    logic        v;
    logic [7:0]  din;
    logic [7:0]  e_data;
    logic        e_lock;
    logic        e_busy;
    logic        e_ready;
    logic [15:0] e_lc;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  logic        seq_ready [8];
  logic        b_lock_exp [8];
  logic [7:0]  b_data_exp [8];
  logic        b_busy_exp [8];
  logic [15:0] b_lc_exp [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sv(input int i, input logic v, input logic [7:0] din, input logic [7:0] ed,
                    input logic el, input logic eb, input logic er, input logic [15:0] lc);
    vecs[i] = '{v, din, ed, el, eb, er, lc};
  endtask

  // Each row: inputs driven before an edge, outputs expected just after it.
  task automatic apply_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      in_valid = vecs[i].v;
      in_data  = vecs[i].din;
      @(posedge sys_clk);
      #1;
      $display("vec %0d: in_valid=%0b in_data=%h -> data=%h lock=%0b busy=%0b ready=%0b lc=%0d",
               i, vecs[i].v, vecs[i].din, digital_data, dac_lock_en, busy, in_ready, lock_count);
      check($sformatf("vec%0d digital_data", i), 32'(digital_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d dac_lock_en", i), 32'(dac_lock_en), 32'(vecs[i].e_lock));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d lock_count", i), 32'(lock_count), 32'(vecs[i].e_lc));
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] applied [$];
    logic [7:0] held;
    logic       prev_lock;
    logic       pre_ready;
    int         accepted;

    // Single code A5, then 01..04 back-to-back (5-cycle period).
    sv( 0, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0);
    sv( 1, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b1, 16'd0);
    sv( 2, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b1, 16'd0);
    sv( 3, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b1, 16'd0);
    sv( 4, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b1, 16'd1);
    sv( 5, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1, 16'd1);
    sv( 6, 1'b1, 8'h01, 8'hA5, 1'b0, 1'b1, 1'b1, 16'd1);
    sv( 7, 1'b1, 8'h02, 8'h01, 1'b0, 1'b1, 1'b1, 16'd1);
    sv( 8, 1'b1, 8'h03, 8'h01, 1'b1, 1'b1, 1'b1, 16'd1);
    sv( 9, 1'b1, 8'h04, 8'h01, 1'b1, 1'b1, 1'b1, 16'd1);
    sv(10, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 16'd2);
    sv(11, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 16'd2);
    sv(12, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b1, 16'd2);
    sv(13, 1'b0, 8'h00, 8'h02, 1'b1, 1'b1, 1'b1, 16'd2);
    sv(14, 1'b0, 8'h00, 8'h02, 1'b1, 1'b1, 1'b1, 16'd2);
    sv(15, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b1, 16'd3);
    sv(16, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b1, 16'd3);
    sv(17, 1'b0, 8'h00, 8'h03, 1'b0, 1'b1, 1'b1, 16'd3);
    sv(18, 1'b0, 8'h00, 8'h03, 1'b1, 1'b1, 1'b1, 16'd3);
    sv(19, 1'b0, 8'h00, 8'h03, 1'b1, 1'b1, 1'b1, 16'd3);
    sv(20, 1'b0, 8'h00, 8'h03, 1'b0, 1'b1, 1'b1, 16'd4);
    sv(21, 1'b0, 8'h00, 8'h03, 1'b0, 1'b1, 1'b1, 16'd4);
    sv(22, 1'b0, 8'h00, 8'h04, 1'b0, 1'b1, 1'b1, 16'd4);
    sv(23, 1'b0, 8'h00, 8'h04, 1'b1, 1'b1, 1'b1, 16'd4);
    sv(24, 1'b0, 8'h00, 8'h04, 1'b1, 1'b1, 1'b1, 16'd4);
    sv(25, 1'b0, 8'h00, 8'h04, 1'b0, 1'b1, 1'b1, 16'd5);
    sv(26, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b1, 16'd5);

    seq_ready  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    b_lock_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    b_data_exp = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    b_busy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    b_lc_exp   = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1};

    sys_rst_n = 1'b0;
    b_rst_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    b_valid   = 1'b0;
    b_data    = 8'h00;

    @(posedge sys_clk);
    #1;
    check("reset digital_data", 32'(digital_data), 32'h0);
    check("reset dac_lock_en", 32'(dac_lock_en), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h1);
    check("reset lock_count", 32'(lock_count), 32'h0);
    check("reset b in_ready", 32'(b_ready), 32'h1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    b_rst_n   = 1'b1;
    @(posedge sys_clk);
    #1;

    apply_rows(0, NVEC - 1);

    // Six codes with in_valid held: FIFO fills, and a pop does not free a push slot on that edge.
    accepted  = 0;
    prev_lock = 1'b0;
    held      = 8'h00;
    for (int cyc = 0; cyc < 45; cyc++) begin
      in_valid  = (accepted < 6);
      in_data   = 8'h10 + 8'(accepted);
      pre_ready = in_ready;
      @(posedge sys_clk);
      #1;
      if (in_valid && pre_ready) begin
        $display("push code %h accepted at cycle %0d", in_data, cyc);
        accepted++;
      end
      if (cyc < 8) check($sformatf("burst cyc%0d in_ready", cyc), 32'(in_ready), 32'(seq_ready[cyc]));
      if (dac_lock_en && !prev_lock) begin
        applied.push_back(digital_data);
        held = digital_data;
        $display("lock pulse applied code %h at cycle %0d", digital_data, cyc);
      end else if (dac_lock_en) begin
        check($sformatf("burst cyc%0d data stable under lock", cyc), 32'(digital_data), 32'(held));
      end
      prev_lock = dac_lock_en;
    end
    in_valid = 1'b0;
    check("burst accepted", 32'(accepted), 32'd6);
    check("burst pulses", 32'(applied.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < applied.size()) check($sformatf("burst order %0d", i), 32'(applied[i]), 32'h10 + 32'(i));
    end
    check("burst lock_count", 32'(lock_count), 32'd11);
    check("burst busy idle", 32'(busy), 32'h0);

    // Reset in the middle of LOCK with codes still buffered.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    @(posedge sys_clk);
    #1;
    in_data = 8'h5B;
    @(posedge sys_clk);
    #1;
    in_data = 8'h5C;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    check("pre-reset dac_lock_en", 32'(dac_lock_en), 32'h1);
    check("pre-reset digital_data", 32'(digital_data), 32'h5A);
    #3;
    sys_rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-lock: data=%h lock=%0b", digital_data, dac_lock_en);
    check("async reset dac_lock_en", 32'(dac_lock_en), 32'h0);
    check("async reset digital_data", 32'(digital_data), 32'h0);
    check("async reset busy", 32'(busy), 32'h0);
    check("async reset in_ready", 32'(in_ready), 32'h1);
    check("async reset lock_count", 32'(lock_count), 32'h0);
    #3;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    check("post reset busy", 32'(busy), 32'h0);
    apply_rows(0, 5);

    // lock_count wrap from 0xFFFF.
    force dut.lock_count_reg = 16'hFFFF;
    #1;
    release dut.lock_count_reg;
    #1;
    check("preload lock_count", 32'(lock_count), 32'hFFFF);
    @(posedge sys_clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    $display("wrap code %h: lock_count=%h", digital_data, lock_count);
    check("wrap lock_count", 32'(lock_count), 32'h0);
    check("wrap digital_data", 32'(digital_data), 32'hC3);
    check("wrap dac_lock_en", 32'(dac_lock_en), 32'h0);

    // SETUP=3, LOCK=1, HOLD=2 instance.
    b_valid = 1'b1;
    b_data  = 8'hFF;
    for (int e = 0; e < 8; e++) begin
      @(posedge sys_clk);
      #1;
      b_valid = 1'b0;
      $display("cfg-b edge %0d: data=%h lock=%0b busy=%0b lc=%0d", e, b_digital, b_lock, b_busy, b_lc);
      check($sformatf("cfgb e%0d dac_lock_en", e), 32'(b_lock), 32'(b_lock_exp[e]));
      check($sformatf("cfgb e%0d digital_data", e), 32'(b_digital), 32'(b_data_exp[e]));
      check($sformatf("cfgb e%0d busy", e), 32'(b_busy), 32'(b_busy_exp[e]));
      check($sformatf("cfgb e%0d lock_count", e), 32'(b_lc), 32'(b_lc_exp[e]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
